// File: rtl/acc_tree_sched.sv
`default_nettype none
// ============================================================================
// Module   : acc_tree_sched
// Purpose  : Schedules window issue into an external adder tree, adds a
//            per-frame bias with 20-bit saturation, and buffers results in a
//            small FWFT FIFO. Optional ReLU via ACC_TREE_SCHED_RELU_EN.
// Revision : 1.0 - initial release
// ============================================================================
module acc_tree_sched #(
    parameter int N_WIN      = 576,
    parameter int TREE_LAT   = 5,
    parameter int FIFO_DEPTH = 2
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               start_i,
    input  logic signed [19:0] bias_i,
    input  logic               win_valid_i,
    output logic               win_ready_o,
    output logic               tree_en_o,
    input  logic signed [19:0] tree_sum_i,
    output logic               res_valid_o,
    input  logic               res_ready_i,
    output logic signed [19:0] res_data_o,
    output logic               res_last_o,
    output logic               busy_o,
    output logic               done_o
);
    localparam int CW = $clog2(N_WIN + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] C_NWIN    = CW'(N_WIN);
    localparam logic [CW-1:0] C_LAST    = CW'(N_WIN - 1);
    localparam logic [FW-1:0] C_DEPTH   = FW'(FIFO_DEPTH);
    localparam logic [PW-1:0] C_PTR_MAX = PW'(FIFO_DEPTH - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t               state_q;
    logic                 done_q;
    logic signed [19:0]   bias_q;
    logic [CW-1:0]        in_cnt_q;
    logic [CW-1:0]        out_cnt_q;
    logic [TREE_LAT-1:0]  vld_q;
    logic [TREE_LAT-1:0]  vld_d;
    logic signed [19:0]   fifo_mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q;
    logic [PW-1:0]        rd_ptr_q;
    logic [FW-1:0]        fifo_cnt_q;

    logic                 busy;
    logic                 accept;
    logic                 push;
    logic                 pop;
    logic                 stall;
    logic                 vld_top;
    logic                 vld_low_any;
    logic                 head_last;
    logic signed [20:0]   sum_w;
    logic signed [19:0]   sat_w;
    logic signed [19:0]   push_data;

    generate
        if (TREE_LAT > 1) begin : g_vld_multi
            assign vld_low_any = |vld_q[TREE_LAT-2:0];
        end else begin : g_vld_single
            assign vld_low_any = 1'b0;
        end
    endgenerate

    assign busy        = (state_q == ST_BUSY);
    assign vld_top     = vld_q[TREE_LAT-1];
    assign res_valid_o = (fifo_cnt_q != '0);
    assign pop         = res_valid_o & res_ready_i;
    assign push        = vld_top & ((fifo_cnt_q < C_DEPTH) | pop);
    assign stall       = vld_top & ~push;
    assign win_ready_o = busy & ~stall & (in_cnt_q < C_NWIN);
    assign accept      = win_valid_i & win_ready_o;
    assign tree_en_o   = ~stall & (accept | vld_low_any);
    assign head_last   = (out_cnt_q == C_LAST);
    assign res_last_o  = res_valid_o & head_last;
    assign res_data_o  = res_valid_o ? fifo_mem_q[rd_ptr_q] : 20'sd0;
    assign busy_o      = busy;
    assign done_o      = done_q;

    // 21-bit sum overflows the 20-bit range exactly when its top two bits differ
    assign sum_w = {tree_sum_i[19], tree_sum_i} + {bias_q[19], bias_q};
    always_comb begin
        sat_w = sum_w[19:0];
        if (sum_w[20] != sum_w[19]) begin
            sat_w = sum_w[20] ? 20'sh80000 : 20'sh7FFFF;
        end
    end

`ifdef ACC_TREE_SCHED_RELU_EN
    assign push_data = sat_w[19] ? 20'sd0 : sat_w;
`else
    assign push_data = sat_w;
`endif

    // The valid tag travels with the tree data; it only moves when the tree does
    always_comb begin
        vld_d = vld_q;
        if (tree_en_o) begin
            for (int i = TREE_LAT - 1; i > 0; i--) begin
                vld_d[i] = vld_q[i-1];
            end
            vld_d[0] = accept;
        end else if (push) begin
            vld_d[TREE_LAT-1] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= ST_IDLE;
            done_q    <= 1'b0;
            bias_q    <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            vld_q     <= '0;
        end else begin
            vld_q  <= vld_d;
            done_q <= 1'b0;
            if (accept) begin
                in_cnt_q <= in_cnt_q + 1'b1;
            end
            if (pop) begin
                out_cnt_q <= out_cnt_q + 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q   <= ST_BUSY;
                        bias_q    <= bias_i;
                        in_cnt_q  <= '0;
                        out_cnt_q <= '0;
                    end
                end
                ST_BUSY: begin
                    if (pop && head_last) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == C_PTR_MAX) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == C_PTR_MAX) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // Storage needs no reset: the read port is masked while the FIFO is empty
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_acc_tree_sched.sv
`default_nettype none
// Randomized bench for acc_tree_sched: an external tree model feeds the DUT and
// a queue-based scoreboard predicts each result from the accepted windows.
module tb_acc_tree_sched;
    localparam int N_WIN      = 10;
    localparam int TREE_LAT   = 5;
    localparam int FIFO_DEPTH = 2;
`ifdef ACC_TREE_SCHED_RELU_EN
    localparam int SAT_LO_EXP = 0;
`else
    localparam int SAT_LO_EXP = -524288;
`endif

    logic               clk = 1'b0;
    logic               rstn;
    logic               start;
    logic signed [19:0] bias;
    logic               win_valid;
    logic               win_ready;
    logic               tree_en;
    logic signed [19:0] tree_sum;
    logic               res_valid;
    logic               res_ready;
    logic signed [19:0] res_data;
    logic               res_last;
    logic               busy;
    logic               done;
    logic signed [19:0] win_data;

    int total = 0;
    int bad   = 0;

    acc_tree_sched #(
        .N_WIN      (N_WIN),
        .TREE_LAT   (TREE_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .start_i     (start),
        .bias_i      (bias),
        .win_valid_i (win_valid),
        .win_ready_o (win_ready),
        .tree_en_o   (tree_en),
        .tree_sum_i  (tree_sum),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .res_data_o  (res_data),
        .res_last_o  (res_last),
        .busy_o      (busy),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_val(input int d, input int b);
        int s;
        s = d + b;
        if (s > 524287) s = 524287;
        else if (s < -524288) s = -524288;
`ifdef ACC_TREE_SCHED_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    // External adder tree: a plain delay line that advances on tree_en
    logic signed [19:0] pipe [TREE_LAT];
    always @(posedge clk) begin
        if (tree_en) begin
            pipe[0] <= win_data;
            for (int i = 1; i < TREE_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign tree_sum = pipe[TREE_LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model and scoreboard, evaluated mid-cycle for the coming edge
    int exp_q[$];
    bit m_busy = 1'b0;
    bit m_done = 1'b0;
    int m_bias = 0;
    int m_out  = 0;
    bit last_pop;
    int acc_total = 0, pop_total = 0, done_total = 0, ten_total = 0;
    int last_pop_data = 0;

    always @(negedge clk) begin
        if (!rstn) begin
            exp_q.delete();
            m_busy = 1'b0;
            m_done = 1'b0;
            m_out  = 0;
        end else begin
            last_pop = 1'b0;
            check("busy", busy, m_busy);
            check("done", done, m_done);
            if (res_valid && res_ready) begin
                pop_total++;
                if (exp_q.size() == 0) begin
                    check("pop_on_empty", exp_q.size(), 1);
                end else begin
                    check("res_data", res_data, exp_q[0]);
                    check("res_last", res_last, (m_out == N_WIN - 1));
                    last_pop_data = res_data;
                    void'(exp_q.pop_front());
                end
                last_pop = (m_out == N_WIN - 1);
                m_out++;
            end
            if (win_valid && win_ready) begin
                acc_total++;
                exp_q.push_back(exp_val(win_data, m_bias));
            end
            if (tree_en) ten_total++;
            if (done) done_total++;
            m_done = last_pop;
            if (last_pop) begin
                m_busy = 1'b0;
            end else if (start && !m_busy) begin
                m_busy = 1'b1;
                m_bias = bias;
                m_out  = 0;
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_win_ready", win_ready, 0);
        check("rst_tree_en", tree_en, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_last", res_last, 0);
        check("rst_res_data", res_data, 0);
    endtask

    task automatic do_start(input int b);
        @(posedge clk); #1;
        start = 1'b1;
        bias  = 20'(b);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_frame(input int vp, input int rp, input bit rnd, input int cval,
                             input bit hold_start, input int hb);
        int d0 = done_total;
        int p0 = pop_total;
        int n  = 0;
        while (done_total == d0 && n < 3000) begin
            @(posedge clk); #1;
            win_valid = ($urandom_range(0, 99) < vp);
            res_ready = ($urandom_range(0, 99) < rp);
            win_data  = rnd ? 20'($urandom()) : 20'(cval);
            if (hold_start) begin
                start = 1'b1;
                bias  = 20'(hb);
            end
            @(negedge clk); #1;
            n++;
        end
        check("frame_done", done_total - d0, 1);
        check("frame_pops", pop_total - p0, N_WIN);
        check("frame_q_empty", exp_q.size(), 0);
        @(posedge clk); #1;
        start     = 1'b0;
        win_valid = 1'b0;
    endtask

    initial begin
        int d0, p0, t0, a0, t_acc, t_vld, n;
        rstn = 1'b0; start = 1'b0; bias = '0;
        win_valid = 1'b0; win_data = '0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rstn = 1'b1;

        // Basic frame: constant windows, full throughput, latency measurement
        do_start(3);
        win_data = 20'sd10; res_ready = 1'b1; win_valid = 1'b1;
        d0 = done_total; p0 = pop_total; t_acc = -1; t_vld = -1; n = 0;
        while (done_total == d0 && n < 500) begin
            @(negedge clk); #1;
            if (win_valid && win_ready && t_acc < 0) t_acc = cyc + 1;
            if (res_valid && t_vld < 0) t_vld = cyc;
            n++;
        end
        check("first_latency", t_vld - t_acc, TREE_LAT);
        check("basic_done", done_total - d0, 1);
        check("basic_pops", pop_total - p0, N_WIN);
        check("basic_data", last_pop_data, 13);
        win_valid = 1'b0;

        // start held through a busy frame and its done edge; restarts one cycle later
        do_start(7);
        run_frame(70, 70, 1'b1, 0, 1'b1, 12345);
        check("restart_busy", busy, 1);
        run_frame(60, 50, 1'b1, 0, 1'b0, 0);

        for (int k = 0; k < 4; k++) begin
            do_start(int'($urandom()));
            run_frame(int'($urandom_range(30, 100)), int'($urandom_range(30, 100)),
                      1'b1, 0, 1'b0, 0);
        end

        do_start(1000);
        run_frame(100, 100, 1'b0, 524000, 1'b0, 0);
        check("sat_hi", last_pop_data, 524287);
        do_start(-5);
        run_frame(100, 100, 1'b0, -524288, 1'b0, 0);
        check("sat_lo", last_pop_data, SAT_LO_EXP);

        // Backpressure: tree plus FIFO absorb exactly TREE_LAT+FIFO_DEPTH windows
        do_start(0);
        res_ready = 1'b0; win_valid = 1'b1; win_data = 20'sd100;
        a0 = acc_total;
        repeat (20) @(posedge clk);
        @(negedge clk); #1;
        check("stall_accepts", acc_total - a0, FIFO_DEPTH + TREE_LAT);
        check("stall_tree_en", tree_en, 0);
        check("stall_win_ready", win_ready, 0);
        run_frame(100, 100, 1'b0, 77, 1'b0, 0);

        // Single window into an idle tree, then reset with windows in flight
        do_start(2);
        res_ready = 1'b1; win_valid = 1'b1; win_data = 20'sd50;
        t0 = ten_total; p0 = pop_total;
        @(posedge clk); #1;
        win_valid = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk); #1;
        check("single_tree_en", ten_total - t0, TREE_LAT);
        check("single_pops", pop_total - p0, 1);
        @(posedge clk); #1;
        win_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        win_valid = 1'b0; res_ready = 1'b0;
        @(posedge clk); #3;
        rstn = 1'b0;
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        do_start(-20);
        run_frame(80, 80, 1'b1, 0, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
